// File: rtl/round_pkg.sv
// Shared encodings and round rules for the cat/dog/chicken round sequencer.
package round_pkg;
  localparam logic [2:0] CAT_OH     = 3'b001;
  localparam logic [2:0] DOG_OH     = 3'b010;
  localparam logic [2:0] CHICKEN_OH = 3'b100;

  localparam logic [1:0] CAT     = 2'd0;
  localparam logic [1:0] DOG     = 2'd1;
  localparam logic [1:0] CHICKEN = 2'd2;

  typedef enum logic [2:0] {P1_WAIT, P2_WAIT, RESOLVE, DRAW, CHECK, OVER} state_t;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == DOG && b == CAT) || (a == CAT && b == CHICKEN) ||
           (a == CHICKEN && b == DOG);
  endfunction

  // Anything that is not a clean one-hot selection counts as cat.
  function automatic logic [1:0] decode(input logic [2:0] oh);
    case (oh)
      DOG_OH:     return DOG;
      CHICKEN_OH: return CHICKEN;
      default:    return CAT;
    endcase
  endfunction
endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for an active-low key plus a registered one-cycle press pulse.
module key_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);
  logic sync0_q, sync1_q, prev_q, press_q;

  // Reset to the released (high) level so no press is seen coming out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync0_q <= key_n_i;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      press_q <= prev_q & ~sync1_q;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/round_sequencer.sv
// Round controller: collects both choices, scores the round, hands off a redraw, detects match end.
module round_sequencer
  import round_pkg::*;
#(
  parameter int WIN_SCORE = 5,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               stateReset,
  input  logic               userCont,
  input  logic [2:0]         choice,
  input  logic               draw_done,
  output logic               draw_req,
  output logic [3:0]         scenario,
  output logic [SCORE_W-1:0] player1,
  output logic [SCORE_W-1:0] player2,
  output logic               winner1,
  output logic               winner2,
  output logic               game_over,
  output logic               busy
);
  localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [1:0]         p1_q, p2_q, ch_idx;
  logic [3:0]         scen_q;
  logic [SCORE_W-1:0] p1s_q, p2s_q;
  logic               w1_q, w2_q, req_q, over_q, busy_q, press;

  key_edge_sync u_cont (
    .clk_i   (clk),
    .rst_i   (stateReset),
    .key_n_i (userCont),
    .press_o (press)
  );

  assign ch_idx = decode(choice);

  always_ff @(posedge clk) begin
    if (stateReset) begin
      state_q <= P1_WAIT;
      p1_q    <= CAT;
      p2_q    <= CAT;
      scen_q  <= '0;
      p1s_q   <= '0;
      p2s_q   <= '0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      req_q   <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      w1_q <= 1'b0;
      w2_q <= 1'b0;
      case (state_q)
        P1_WAIT: if (press) begin
          p1_q    <= ch_idx;
          state_q <= P2_WAIT;
        end
        // Winner pulses are registered here so they are visible during RESOLVE.
        P2_WAIT: if (press) begin
          p2_q    <= ch_idx;
          w1_q    <= beats(p1_q, ch_idx);
          w2_q    <= beats(ch_idx, p1_q);
          busy_q  <= 1'b1;
          state_q <= RESOLVE;
        end
        RESOLVE: begin
          scen_q <= 4'(p1_q) * 4'd3 + 4'(p2_q);
          if (beats(p1_q, p2_q) && p1s_q < WIN_Q) p1s_q <= p1s_q + 1'b1;
          if (beats(p2_q, p1_q) && p2s_q < WIN_Q) p2s_q <= p2s_q + 1'b1;
          req_q   <= 1'b1;
          state_q <= DRAW;
        end
        DRAW: if (draw_done) begin
          req_q   <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (p1s_q == WIN_Q || p2s_q == WIN_Q) begin
            over_q  <= 1'b1;
            state_q <= OVER;
          end else begin
            state_q <= P1_WAIT;
          end
        end
        OVER: if (press) begin
          p1s_q   <= '0;
          p2s_q   <= '0;
          p1_q    <= CAT;
          p2_q    <= CAT;
          over_q  <= 1'b0;
          state_q <= P1_WAIT;
        end
        default: state_q <= P1_WAIT;
      endcase
    end
  end

  assign draw_req  = req_q;
  assign scenario  = scen_q;
  assign player1   = p1s_q;
  assign player2   = p2s_q;
  assign winner1   = w1_q;
  assign winner2   = w2_q;
  assign game_over = over_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench: stimulus queues expected round results, a monitor checks them at each redraw request.
module tb_round_sequencer;
  logic       clk = 1'b0;
  logic       stateReset = 1'b1;
  logic       userCont = 1'b1;
  logic [2:0] choice = 3'b000;
  logic       draw_done = 1'b0;
  logic       draw_req, winner1, winner2, game_over, busy;
  logic [3:0] scenario, player1, player2;

  round_sequencer #(.WIN_SCORE(5), .SCORE_W(4)) dut (
    .clk(clk), .stateReset(stateReset), .userCont(userCont), .choice(choice),
    .draw_done(draw_done), .draw_req(draw_req), .scenario(scenario),
    .player1(player1), .player2(player2), .winner1(winner1), .winner2(winner2),
    .game_over(game_over), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {int scen; int s1; int s2; int w1; int w2;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Monitor: every rising draw_req presents a round result.
  logic dr_prev = 1'b0, w1_prev = 1'b0, w2_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (draw_req === 1'b1 && dr_prev === 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected_round", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("scenario", int'(scenario), e.scen);
          chk("player1", int'(player1), e.s1);
          chk("player2", int'(player2), e.s2);
          chk("winner1_pulse", int'(w1_prev), e.w1);
          chk("winner2_pulse", int'(w2_prev), e.w2);
          chk("winner_width", int'(winner1 | winner2), 0);
        end
      end
      dr_prev = draw_req;
      w1_prev = winner1;
      w2_prev = winner2;
    end
  end

  task automatic press(input logic [2:0] ch);
    @(negedge clk);
    choice   = ch;
    userCont = 1'b0;
    repeat (6) @(negedge clk);
    userCont = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic play(input logic [2:0] c1, input logic [2:0] c2, input int scen,
                      input int s1, input int s2, input int w1, input int w2);
    exp_t e;
    press(c1);
    e.scen = scen; e.s1 = s1; e.s2 = s2; e.w1 = w1; e.w2 = w2;
    exp_q.push_back(e);
    press(c2);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 30 && draw_req !== 1'b1; i++) @(negedge clk);
    chk("draw_req_seen", int'(draw_req === 1'b1), 1);
  endtask

  task automatic end_draw();
    wait_req();
    repeat (3) @(negedge clk);
    chk("draw_req_held", int'(draw_req), 1);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    chk("draw_req_drop", int'(draw_req), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(negedge clk);
    stateReset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_scenario", int'(scenario), 0);
    chk("rst_scores", int'(player1) + int'(player2), 0);
    chk("rst_flags", int'({draw_req, winner1, winner2, game_over, busy}), 0);

    // Player 1 wins, tie, invalid-as-cat tie
    play(3'b010, 3'b001, 3, 1, 0, 1, 0);
    end_draw();
    play(3'b100, 3'b100, 8, 1, 0, 0, 0);
    end_draw();
    play(3'b011, 3'b001, 0, 1, 0, 0, 0);
    end_draw();

    // Player 2 takes five straight rounds
    for (int r = 1; r <= 5; r++) begin
      play(3'b001, 3'b010, 1, 1, r, 0, 1);
      end_draw();
      if (r == 4) chk("not_over_yet", int'(game_over), 0);
    end
    chk("over_flag", int'(game_over), 1);
    chk("over_p2", int'(player2), 5);
    chk("over_busy", int'(busy), 0);
    press(3'b001);
    chk("restart_scores", int'(player1) + int'(player2), 0);
    chk("restart_over", int'(game_over), 0);

    // Presses during a long DRAW are discarded
    play(3'b001, 3'b100, 2, 1, 0, 1, 0);
    wait_req();
    repeat (3) press(3'b010);
    chk("draw_hold_req", int'(draw_req), 1);
    chk("draw_hold_busy", int'(busy), 1);
    end_draw();
    chk("back_idle_busy", int'(busy), 0);
    play(3'b100, 3'b001, 6, 1, 1, 0, 1);
    end_draw();

    // Reset mid-DRAW
    play(3'b010, 3'b010, 4, 1, 1, 0, 0);
    wait_req();
    stateReset = 1'b1;
    @(negedge clk);
    stateReset = 1'b0;
    chk("rst_draw_req", int'(draw_req), 0);
    chk("rst_draw_scores", int'(player1) + int'(player2), 0);
    chk("rst_draw_scen", int'(scenario), 0);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_req", int'(draw_req), 0);
    chk("late_done_busy", int'(busy), 0);
    play(3'b010, 3'b100, 5, 0, 1, 0, 1);
    end_draw();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
